// File: rtl/pulse_pkg.sv
// Shared constants for the pulse BRAM reader: address stride, fp32 zero, FSM encoding.
package pulse_pkg;

   localparam int          ADDR_STEP = 4;
   localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
   localparam int          FRAME_W   = 16;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_LATCH = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_CLEAR = 3'd4;

endpackage

// File: rtl/pulse_bram_reader.sv
// Streams pin/pulse BRAM words in lockstep as marker+fp32 samples over valid/ready.
// Optional CLEAR_ON_READ_EN: zero each word on both BRAMs right after it is consumed.
module pulse_bram_reader
   import pulse_pkg::*;
#(
   parameter int DEPTH     = 2048,
   parameter int ADDR_STEP = pulse_pkg::ADDR_STEP,
   parameter int DATA_W    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_en,
   output logic [31:0]        bram_addr,
   output logic               ena_pin,
   output logic               bram_we_pin,
   output logic [DATA_W-1:0]  bram_data_in,
   input  logic [DATA_W-1:0]  bram_data_out,
   output logic               ena_pulse,
   output logic               bram_we_pulse,
   output logic [DATA_W-1:0]  bram_data_in_pulse,
   input  logic [DATA_W-1:0]  bram_data_out_pulse,
   output logic [DATA_W-1:0]  m_data,
   output logic               m_marker,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               busy,
   output logic               done,
   output logic [FRAME_W-1:0] frame_count
);

   localparam int               IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(DEPTH - 1);

   logic [2:0]       state;
   logic [IDX_W-1:0] idx;
   logic             last_word;
   logic [2:0]       adv_state;
   logic [IDX_W-1:0] adv_idx;

   assign last_word = (idx == LAST);

   // Where the walk goes after a word is finished; loop_en only matters on the last word.
   always_comb begin
      adv_state = S_ISSUE;
      adv_idx   = idx + 1'b1;
      if (last_word) begin
         adv_idx   = '0;
         adv_state = loop_en ? S_ISSUE : S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      done <= 1'b0;
      if (!rst_n) begin
         state       <= S_IDLE;
         idx         <= '0;
         m_data      <= '0;
         m_marker    <= 1'b0;
         m_valid     <= 1'b0;
         frame_count <= '0;
      end else if (stop) begin
         state   <= S_IDLE;
         idx     <= '0;
         m_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_ISSUE;
                  idx   <= '0;
               end
            end
            S_ISSUE: state <= S_LATCH;
            S_LATCH: begin
               m_data   <= bram_data_out_pulse;
               m_marker <= (bram_data_out != '0);
               m_valid  <= 1'b1;
               state    <= S_HOLD;
            end
            S_HOLD: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
`ifdef CLEAR_ON_READ_EN
                  state   <= S_CLEAR;
`else
                  state   <= adv_state;
                  idx     <= adv_idx;
                  done    <= last_word && !loop_en;
                  if (last_word) frame_count <= frame_count + 1'b1;
`endif
               end
            end
`ifdef CLEAR_ON_READ_EN
            S_CLEAR: begin
               state <= adv_state;
               idx   <= adv_idx;
               done  <= last_word && !loop_en;
               if (last_word) frame_count <= frame_count + 1'b1;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

   // Address follows idx for the whole word, so CLEAR rewrites the word just read.
   assign bram_addr = 32'(idx) * 32'(ADDR_STEP);
   assign busy      = (state != S_IDLE);

`ifdef CLEAR_ON_READ_EN
   logic clr;
   assign clr                = (state == S_CLEAR);
   assign ena_pin            = (state == S_ISSUE) || clr;
   assign ena_pulse          = (state == S_ISSUE) || clr;
   assign bram_we_pin        = clr;
   assign bram_we_pulse      = clr;
   assign bram_data_in       = DATA_W'(FP32_ZERO);
   assign bram_data_in_pulse = DATA_W'(FP32_ZERO);
`else
   assign ena_pin            = (state == S_ISSUE);
   assign ena_pulse          = (state == S_ISSUE);
   assign bram_we_pin        = 1'b0;
   assign bram_we_pulse      = 1'b0;
   assign bram_data_in       = '0;
   assign bram_data_in_pulse = '0;
`endif

endmodule

// File: tb/tb_pulse_bram_reader.sv
// Bench for pulse_bram_reader (DEPTH=4) with behavioural BRAM models and a sample-order model.
module tb_pulse_bram_reader;

   localparam int DEPTH = 4;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          loop_en = 1'b0;
   logic          m_ready = 1'b0;
   logic [31:0]   bram_addr;
   logic          ena_pin, bram_we_pin, ena_pulse, bram_we_pulse;
   logic [DW-1:0] bram_data_in, bram_data_in_pulse;
   logic [DW-1:0] pin_q, pulse_q;
   logic [DW-1:0] m_data;
   logic          m_marker, m_valid, busy, done;
   logic [15:0]   frame_count;

   always #5 clk = ~clk;

   pulse_bram_reader #(.DEPTH(DEPTH), .ADDR_STEP(4), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
      .bram_addr(bram_addr),
      .ena_pin(ena_pin), .bram_we_pin(bram_we_pin), .bram_data_in(bram_data_in),
      .bram_data_out(pin_q),
      .ena_pulse(ena_pulse), .bram_we_pulse(bram_we_pulse),
      .bram_data_in_pulse(bram_data_in_pulse), .bram_data_out_pulse(pulse_q),
      .m_data(m_data), .m_marker(m_marker), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .done(done), .frame_count(frame_count)
   );

   // BRAM models: 1-cycle registered read, write-enable honoured, bench-side preload.
   logic [DW-1:0] pin_mem [DEPTH];
   logic [DW-1:0] pulse_mem [DEPTH];
   logic [DW-1:0] ld_pin [DEPTH];
   logic [DW-1:0] ld_pulse [DEPTH];
   logic          ld = 1'b0;
   logic [1:0]    wa;
   assign wa = bram_addr[3:2];

   always @(posedge clk) begin
      if (ld) begin
         for (int i = 0; i < DEPTH; i++) begin
            pin_mem[i]   <= ld_pin[i];
            pulse_mem[i] <= ld_pulse[i];
         end
      end else begin
         if (ena_pin) begin
            if (bram_we_pin) pin_mem[wa] <= bram_data_in;
            pin_q <= pin_mem[wa];
         end
         if (ena_pulse) begin
            if (bram_we_pulse) pulse_mem[wa] <= bram_data_in_pulse;
            pulse_q <= pulse_mem[wa];
         end
      end
   end

   int done_cnt = 0;
   int we_cnt = 0;
   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (bram_we_pin || bram_we_pulse) we_cnt <= we_cnt + 1;
   end

   typedef struct {
      logic [31:0] pin;
      logic [31:0] pulse;
      logic [31:0] data;
      logic        marker;
   } vec_t;
   vec_t tbl [DEPTH];

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_tbl();
      for (int i = 0; i < DEPTH; i++) begin
         ld_pin[i]   = tbl[i].pin;
         ld_pulse[i] = tbl[i].pulse;
      end
      ld = 1'b1;
      tick();
      ld = 1'b0;
   endtask

   // Wait (bounded) for a presented beat, sample it, then let the handshake edge pass.
   task automatic get_beat(output logic [31:0] d, output logic mk, output logic [31:0] a);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (m_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL beat_timeout: got m_valid=0 want 1 within 20 cycles");
      end
      d  = m_data;
      mk = m_marker;
      a  = bram_addr;
      tick();
   endtask

   task automatic expect_beat(input string nm, input int k);
      logic [31:0] d, a;
      logic        mk;
      get_beat(d, mk, a);
      chk({nm, "_data"}, d, tbl[k].data);
      chk({nm, "_marker"}, 32'(mk), 32'(tbl[k].marker));
      chk({nm, "_addr"}, a, 32'(k * 4));
   endtask

   task automatic wait_valid(input string nm);
      for (int i = 0; i < 20; i++) begin
         if (m_valid) break;
         tick();
      end
      chk({nm, "_valid"}, 32'(m_valid), 32'd1);
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "_addr"}, bram_addr, 32'h0);
      chk({nm, "_ena"}, {30'd0, ena_pin, ena_pulse}, 32'h0);
      chk({nm, "_we"}, {30'd0, bram_we_pin, bram_we_pulse}, 32'h0);
      chk({nm, "_din"}, bram_data_in | bram_data_in_pulse, 32'h0);
      chk({nm, "_mdata"}, m_data, 32'h0);
      chk({nm, "_mflags"}, {28'd0, m_marker, m_valid, done, busy}, 32'h0);
      chk({nm, "_fc"}, 32'(frame_count), 32'h0);
   endtask

   initial begin
      int dc, wc, fc_exp;
      tbl[0] = '{32'h0, 32'h3F800000, 32'h3F800000, 1'b0};
      tbl[1] = '{32'h1, 32'h3F000000, 32'h3F000000, 1'b1};
      tbl[2] = '{32'h0, 32'h00000000, 32'h00000000, 1'b0};
      tbl[3] = '{32'h0, 32'h3DA339C1, 32'h3DA339C1, 1'b0};

      tick();
      tick();
      load_tbl();
      check_reset("reset");
      rst_n   = 1'b1;
      m_ready = 1'b1;
      tick();

      // single frame, latency and done
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_issue", {29'd0, busy, ena_pin, ena_pulse}, 32'h7);
      chk("t1_issue_valid", 32'(m_valid), 32'd0);
      tick();
      chk("t1_latch_valid", 32'(m_valid), 32'd0);
      tick();
      chk("t1_first_valid", 32'(m_valid), 32'd1);
      dc = done_cnt;
      for (int k = 0; k < DEPTH; k++) expect_beat("t1_beat", k);
`ifdef CLEAR_ON_READ_EN
      tick();
`endif
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_fc", 32'(frame_count), 32'd1);
      tick();
      chk("t1_done_low", 32'(done), 32'd0);
      chk("t1_busy_low", 32'(busy), 32'd0);
      chk("t1_done_once", 32'(done_cnt - dc), 32'd1);

      // back-pressure on beat 1
      load_tbl();
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_beat("t2_b0", 0);
      m_ready = 1'b0;
      wait_valid("t2_hold_start");
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t2_hold_valid", 32'(m_valid), 32'd1);
         chk("t2_hold_data", m_data, 32'h3F000000);
         chk("t2_hold_addr", bram_addr, 32'h4);
      end
      m_ready = 1'b1;
      for (int k = 1; k < DEPTH; k++) expect_beat("t2_beat", k);
      tick();
      chk("t2_fc", 32'(frame_count), 32'd2);

      // looping, wrap to address 0
      load_tbl();
      loop_en = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         logic [31:0] d, a;
         logic        mk;
         wait_valid("t3_wait");
         if (k == 4) begin
            chk("t3_wrap_addr", bram_addr, 32'h0);
            chk("t3_fc_1", 32'(frame_count), 32'd3);
         end
         if (k == 8) chk("t3_fc_2", 32'(frame_count), 32'd4);
         get_beat(d, mk, a);
         chk("t3_data", d, tbl[k % DEPTH].data);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      loop_en = 1'b0;
      chk("t3_stop_busy", 32'(busy), 32'd0);

      // stop in HOLD of beat 2, with a simultaneous start
      load_tbl();
      dc = done_cnt;
      wc = we_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_beat("t4_beat", 0);
      expect_beat("t4_beat", 1);
      m_ready = 1'b0;
      wait_valid("t4_hold");
      stop  = 1'b1;
      start = 1'b1;
      tick();
      stop  = 1'b0;
      start = 1'b0;
      chk("t4_valid", 32'(m_valid), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);
      tick();
      chk("t4_still_idle", 32'(busy), 32'd0);
      chk("t4_no_done", 32'(done_cnt - dc), 32'd0);
      chk("t4_fc", 32'(frame_count), 32'd4);
`ifdef CLEAR_ON_READ_EN
      chk("t4_clear_writes", 32'(we_cnt - wc), 32'd2);
`else
      chk("t4_no_writes", 32'(we_cnt - wc), 32'd0);
`endif

      // reset mid-frame, then replay from word 0
      load_tbl();
      m_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_beat("t5_pre", 0);
      m_ready = 1'b0;
      wait_valid("t5_hold");
      rst_n = 1'b0;
      tick();
      check_reset("t5_rst");
      rst_n   = 1'b1;
      m_ready = 1'b1;
      load_tbl();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < DEPTH; k++) expect_beat("t5_beat", k);
      tick();
      chk("t5_fc", 32'(frame_count), 32'd1);
      fc_exp = 1;

      // randomized contents and back-pressure against the in-order sample model
      for (int t = 0; t < 8; t++) begin
         logic [31:0] exp_d [DEPTH];
         logic        exp_m [DEPTH];
         logic [31:0] hold_d;
         bit          holding, lp, fin;
         int          got, nb;
         for (int i = 0; i < DEPTH; i++) begin
            tbl[i].pin    = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
            tbl[i].pulse  = $urandom;
            exp_d[i]      = tbl[i].pulse;
            exp_m[i]      = (tbl[i].pin != 32'h0);
         end
         load_tbl();
         lp      = ($urandom_range(0, 1) == 1);
         nb      = lp ? 6 : DEPTH;
         loop_en = lp;
         dc      = done_cnt;
         got     = 0;
         holding = 1'b0;
         hold_d  = '0;
         fin     = 1'b0;
         start   = 1'b1;
         tick();
         start = 1'b0;
         for (int c = 0; c < 300 && !fin; c++) begin
            if (holding) chk("rnd_hold", {m_valid, m_data[30:0]}, {1'b1, hold_d[30:0]});
            m_ready = ($urandom_range(0, 2) != 0);
            if (m_valid && m_ready) begin
               chk("rnd_data", m_data, exp_d[got % DEPTH]);
               chk("rnd_marker", 32'(m_marker), 32'(exp_m[got % DEPTH]));
               got++;
            end
            holding = m_valid && !m_ready;
            hold_d  = m_data;
            tick();
            if (got == nb) begin
               if (lp) begin
                  stop = 1'b1;
                  tick();
                  stop = 1'b0;
               end
               fin = 1'b1;
            end
         end
         loop_en = 1'b0;
         m_ready = 1'b1;
         tick();
         tick();
         fc_exp++;
         chk("rnd_beats", 32'(got), 32'(nb));
         chk("rnd_fc", 32'(frame_count), 32'(fc_exp));
         chk("rnd_done", 32'(done_cnt - dc), lp ? 32'd0 : 32'd1);
         chk("rnd_idle", 32'(busy), 32'd0);
      end

      // memory side effects of a full frame
      tbl[0] = '{32'h0, 32'h3F800000, 32'h3F800000, 1'b0};
      tbl[1] = '{32'h1, 32'h3F000000, 32'h3F000000, 1'b1};
      tbl[2] = '{32'h0, 32'h00000000, 32'h00000000, 1'b0};
      tbl[3] = '{32'h0, 32'h3DA339C1, 32'h3DA339C1, 1'b0};
      load_tbl();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < DEPTH; k++) expect_beat("t6_beat", k);
      tick();
      tick();
      for (int i = 0; i < DEPTH; i++) begin
`ifdef CLEAR_ON_READ_EN
         chk("t6_pin_cleared", pin_mem[i], 32'h0);
         chk("t6_pulse_cleared", pulse_mem[i], 32'h0);
`else
         chk("t6_pin_kept", pin_mem[i], tbl[i].pin);
         chk("t6_pulse_kept", pulse_mem[i], tbl[i].pulse);
`endif
      end
`ifndef CLEAR_ON_READ_EN
      chk("t6_never_we", 32'(we_cnt), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
